au_seq_ctl: RTL and testbench



---
 rtl/au_seq_ctl.sv | 171 +++++++++++++++++
 tb/tb_au_seq_ctl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_seq_ctl.sv
// au_seq_ctl: job sequencer for one packed arithmetic unit.
// Takes a job (control word + beat count), streams operand pairs into the unit through a
// registered stage, and sums the unit's 16-bit results into a wide signed accumulator.
// Control word layout (i_cfg_ctl / o_au_ctl):
//   [3:2] mode  : 0 M8, 1 M4, 2 M2, 3 XNOR
//   [1]   iNumT : 0 unsigned, 1 signed
//   [0]   wNumT : 0 unsigned, 1 signed
module au_seq_ctl #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN_W = 10,
    parameter bit          SAT   = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [3:0]       i_cfg_ctl,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [15:0]      i_ipix,
    input  logic [15:0]      i_wpix,
    output logic [3:0]       o_au_ctl,
    output logic [15:0]      o_au_ipix,
    output logic [15:0]      o_au_wpix,
    input  logic [15:0]      i_au_sum,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [ACC_W-1:0] o_res,
    output logic             o_busy
);

    localparam logic [1:0]       MODE_XNOR = 2'd3;
    localparam int unsigned      EXT_W     = ACC_W - 16;
    localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] LEN_ZERO  = '0;
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           r_state;
    logic [LEN_W-1:0] r_remaining;
    logic             r_stage_v;
    logic             r_cfg_ready;
    logic             r_op_ready;
    logic             r_res_valid;
    logic             r_busy;
    logic [3:0]       r_au_ctl;
    logic [15:0]      r_ipix;
    logic [15:0]      r_wpix;
    logic [ACC_W-1:0] r_acc;

    logic             w_cfg_hs;
    logic             w_op_hs;
    logic             w_sign_ext;
    logic             w_ovf;
    logic [ACC_W-1:0] w_sum_ext;
    logic [ACC_W:0]   w_acc_wide;
    logic [ACC_W-1:0] w_acc_next;

    // Ready flags are only ever high in the state that may accept, so no state term needed.
    assign w_cfg_hs = i_cfg_valid & r_cfg_ready;
    assign w_op_hs  = i_op_valid & r_op_ready;

    // Any signed operand (or XNOR mode) makes the unit's result a signed quantity.
    assign w_sign_ext = (r_au_ctl[3:2] == MODE_XNOR) | r_au_ctl[1] | r_au_ctl[0];
    assign w_sum_ext  = {{EXT_W{w_sign_ext & i_au_sum[15]}}, i_au_sum};

    // One extra bit of headroom exposes signed overflow as a mismatch of the top two bits.
    assign w_acc_wide = {r_acc[ACC_W-1], r_acc} + {w_sum_ext[ACC_W-1], w_sum_ext};
    assign w_ovf      = w_acc_wide[ACC_W] ^ w_acc_wide[ACC_W-1];

    // Saturating or wrapping accumulator update.
    always_comb begin
        w_acc_next = w_acc_wide[ACC_W-1:0];
        if (SAT && w_ovf) begin
            w_acc_next = w_acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Job sequencing FSM with registered handshake/status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_cfg_ready <= 1'b1;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_au_ctl    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_cfg_hs) begin
                        r_au_ctl    <= i_cfg_ctl;
                        r_remaining <= i_cfg_len;
                        r_cfg_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (i_cfg_len != LEN_ZERO) begin
                            r_state    <= StRun;
                            r_op_ready <= 1'b1;
                        end else begin
                            r_state     <= StDone;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (w_op_hs) begin
                        r_remaining <= r_remaining - LEN_ONE;
                        // Ready drops together with the count reaching zero.
                        if (r_remaining == LEN_ONE) begin
                            r_state    <= StDrain;
                            r_op_ready <= 1'b0;
                        end
                    end
                end
                StDrain: begin
                    r_state     <= StDone;
                    r_res_valid <= 1'b1;
                end
                StDone: begin
                    if (i_res_ready) begin
                        r_state     <= StIdle;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Operand stage: loads on a beat handshake, holds otherwise; stage_v marks a fresh beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ipix    <= '0;
            r_wpix    <= '0;
            r_stage_v <= 1'b0;
        end else begin
            r_stage_v <= w_op_hs;
            if (w_op_hs) begin
                r_ipix <= i_ipix;
                r_wpix <= i_wpix;
            end
        end
    end

    // Accumulator: cleared when a job is accepted, adds the unit result of each staged beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (w_cfg_hs) begin
            r_acc <= '0;
        end else if (r_stage_v) begin
            r_acc <= w_acc_next;
        end
    end

    assign o_cfg_ready = r_cfg_ready;
    assign o_op_ready  = r_op_ready;
    assign o_res_valid = r_res_valid;
    assign o_busy      = r_busy;
    assign o_au_ctl    = r_au_ctl;
    assign o_au_ipix   = r_ipix;
    assign o_au_wpix   = r_wpix;
    assign o_res       = r_acc;

endmodule

// File: tb/tb_au_seq_ctl.sv
// Bench for au_seq_ctl: three instances (24-bit saturating, 17-bit saturating, 17-bit
// wrapping) share one stimulus stream; each is fed by its own stand-in unit computing
// ipix + wpix. A job-level model predicts handshakes, operand registers and final sums.
module tb_au_seq_ctl;

    localparam int unsigned LEN_W = 10;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [3:0]       cfg_ctl   = '0;
    logic [LEN_W-1:0] cfg_len   = '0;
    logic             op_valid  = 1'b0;
    logic [15:0]      ipix      = '0;
    logic [15:0]      wpix      = '0;
    logic             res_ready = 1'b0;

    logic        cfg_ready_a, op_ready_a, res_valid_a, busy_a;
    logic [3:0]  au_ctl_a;
    logic [15:0] au_ipix_a, au_wpix_a, au_sum_a;
    logic [23:0] res_a;
    logic        cfg_ready_s, op_ready_s, res_valid_s, busy_s;
    logic [3:0]  au_ctl_s;
    logic [15:0] au_ipix_s, au_wpix_s, au_sum_s;
    logic [16:0] res_s;
    logic        cfg_ready_w, op_ready_w, res_valid_w, busy_w;
    logic [3:0]  au_ctl_w;
    logic [15:0] au_ipix_w, au_wpix_w, au_sum_w;
    logic [16:0] res_w;

    assign au_sum_a = au_ipix_a + au_wpix_a;
    assign au_sum_s = au_ipix_s + au_wpix_s;
    assign au_sum_w = au_ipix_w + au_wpix_w;

    au_seq_ctl #(.ACC_W(24), .LEN_W(LEN_W), .SAT(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready_a),
        .i_cfg_ctl(cfg_ctl), .i_cfg_len(cfg_len), .i_op_valid(op_valid), .o_op_ready(op_ready_a),
        .i_ipix(ipix), .i_wpix(wpix), .o_au_ctl(au_ctl_a), .o_au_ipix(au_ipix_a),
        .o_au_wpix(au_wpix_a), .i_au_sum(au_sum_a), .o_res_valid(res_valid_a),
        .i_res_ready(res_ready), .o_res(res_a), .o_busy(busy_a)
    );
    au_seq_ctl #(.ACC_W(17), .LEN_W(LEN_W), .SAT(1'b1)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready_s),
        .i_cfg_ctl(cfg_ctl), .i_cfg_len(cfg_len), .i_op_valid(op_valid), .o_op_ready(op_ready_s),
        .i_ipix(ipix), .i_wpix(wpix), .o_au_ctl(au_ctl_s), .o_au_ipix(au_ipix_s),
        .o_au_wpix(au_wpix_s), .i_au_sum(au_sum_s), .o_res_valid(res_valid_s),
        .i_res_ready(res_ready), .o_res(res_s), .o_busy(busy_s)
    );
    au_seq_ctl #(.ACC_W(17), .LEN_W(LEN_W), .SAT(1'b0)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready_w),
        .i_cfg_ctl(cfg_ctl), .i_cfg_len(cfg_len), .i_op_valid(op_valid), .o_op_ready(op_ready_w),
        .i_ipix(ipix), .i_wpix(wpix), .o_au_ctl(au_ctl_w), .o_au_ipix(au_ipix_w),
        .o_au_wpix(au_wpix_w), .i_au_sum(au_sum_w), .o_res_valid(res_valid_w),
        .i_res_ready(res_ready), .o_res(res_w), .o_busy(busy_w)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    logic [15:0] dsum [0:3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Add v to a signed w-bit accumulator, clamping or wrapping.
    function automatic longint acc_step(longint acc, longint v, int w, bit sat);
        longint span = longint'(1) <<< w;
        longint hi   = (span >>> 1) - 1;
        longint lo   = -(span >>> 1);
        longint s    = acc + v;
        if (sat) begin
            if (s > hi) s = hi;
            else if (s < lo) s = lo;
        end else begin
            s = s & (span - 1);
            if (s > hi) s = s - span;
        end
        return s;
    endfunction

    function automatic logic [63:0] as_bits(longint v, int w);
        return 64'(v & ((longint'(1) <<< w) - 1));
    endfunction

    // ---------------- job-level reference model ----------------
    int          m_st    = M_IDLE;
    int          m_left  = 0;
    logic [3:0]  m_ctl   = '0;
    logic [15:0] m_ipix  = '0;
    logic [15:0] m_wpix  = '0;
    logic [15:0] m_sum   = '0;
    longint      m_v     = 0;
    longint      m_acc_a = 0;
    longint      m_acc_s = 0;
    longint      m_acc_w = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = M_IDLE; m_left = 0; m_ctl = '0; m_ipix = '0; m_wpix = '0;
            m_acc_a = 0; m_acc_s = 0; m_acc_w = 0;
        end else begin
            case (m_st)
                M_IDLE: if (cfg_valid) begin
                    m_ctl  = cfg_ctl;
                    m_left = int'(cfg_len);
                    m_acc_a = 0; m_acc_s = 0; m_acc_w = 0;
                    m_st = (m_left > 0) ? M_RUN : M_DONE;
                end
                M_RUN: if (op_valid && m_left > 0) begin
                    m_sum = ipix + wpix;
                    if (m_ctl[3:2] == 2'd3 || m_ctl[1] || m_ctl[0])
                        m_v = longint'($signed(m_sum));
                    else
                        m_v = longint'(m_sum);
                    m_acc_a = acc_step(m_acc_a, m_v, 24, 1'b1);
                    m_acc_s = acc_step(m_acc_s, m_v, 17, 1'b1);
                    m_acc_w = acc_step(m_acc_w, m_v, 17, 1'b0);
                    m_ipix = ipix;
                    m_wpix = wpix;
                    m_left--;
                    if (m_left == 0) m_st = M_DRAIN;
                end
                M_DRAIN: m_st = M_DONE;
                M_DONE:  if (res_ready) m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [3:0]  exp_flags;
    logic [35:0] exp_au;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_flags = {m_st == M_IDLE, (m_st == M_RUN) && (m_left > 0), m_st == M_DONE,
                         m_st != M_IDLE};
            exp_au = {m_ctl, m_ipix, m_wpix};
            check("flags_a", 64'({cfg_ready_a, op_ready_a, res_valid_a, busy_a}), 64'(exp_flags));
            check("flags_s", 64'({cfg_ready_s, op_ready_s, res_valid_s, busy_s}), 64'(exp_flags));
            check("flags_w", 64'({cfg_ready_w, op_ready_w, res_valid_w, busy_w}), 64'(exp_flags));
            check("au_a", 64'({au_ctl_a, au_ipix_a, au_wpix_a}), 64'(exp_au));
            check("au_s", 64'({au_ctl_s, au_ipix_s, au_wpix_s}), 64'(exp_au));
            check("au_w", 64'({au_ctl_w, au_ipix_w, au_wpix_w}), 64'(exp_au));
            if (m_st == M_DONE) begin
                check("res_a", 64'(res_a), as_bits(m_acc_a, 24));
                check("res_s", 64'(res_s), as_bits(m_acc_s, 17));
                check("res_w", 64'(res_w), as_bits(m_acc_w, 17));
            end
        end
    end

    // ---------------- stimulus ----------------
    // One job: cfg handshake, len beats (directed sums from dsum or random operands),
    // optional valid pattern / random stalls, result held res_wait cycles before consuming.
    task automatic run_job(input logic [3:0] ctl, input int len, input bit directed,
                           input int stall_pct, input logic [7:0] vpat, input int res_wait,
                           output longint ra, output longint rs, output longint rw,
                           output int lat);
        bit rdy;
        bit got;
        int sent;
        int cyc;
        cfg_valid = 1'b1;
        cfg_ctl   = ctl;
        cfg_len   = LEN_W'(len);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); rdy = cfg_ready_a;
            @(posedge clk); #1;
            if (rdy) begin got = 1'b1; break; end
        end
        cfg_valid = 1'b0;
        if (!got) check("cfg_timeout", 64'd0, 64'd1);
        sent = 0;
        cyc  = 0;
        while (sent < len && cyc < 40 * len + 40) begin
            if (vpat != 8'h00 && cyc < 8) op_valid = vpat[cyc];
            else if (stall_pct > 0) op_valid = ($urandom_range(99) >= stall_pct);
            else op_valid = 1'b1;
            if (directed) begin
                ipix = dsum[sent];
                wpix = 16'h0000;
            end else begin
                ipix = 16'($urandom);
                wpix = 16'($urandom);
            end
            // Junk config traffic while busy must be ignored.
            cfg_valid = 1'($urandom_range(1));
            cfg_ctl   = 4'($urandom);
            cfg_len   = LEN_W'($urandom);
            @(negedge clk); rdy = op_ready_a;
            @(posedge clk); #1;
            if (op_valid && rdy) sent++;
            cyc++;
        end
        if (sent != len) check("op_timeout", 64'(sent), 64'(len));
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid_a) begin got = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
            op_valid = 1'($urandom_range(1));
        end
        if (!got) check("res_timeout", 64'd0, 64'd1);
        ra = longint'(res_a);
        rs = longint'(res_s);
        rw = longint'(res_w);
        for (int i = 0; i < res_wait; i++) begin
            @(posedge clk); #1;
            op_valid = 1'($urandom_range(1));
        end
        cfg_valid = 1'b0;
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint ra, rs, rw;
        int     lat, len;

        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rst_flags", 64'({cfg_ready_a, op_ready_a, res_valid_a, busy_a}), 64'b1000);
        check("rst_res", 64'(res_a), 64'd0);
        check("rst_au", 64'({au_ctl_a, au_ipix_a, au_wpix_a}), 64'd0);
        @(posedge clk); #1;

        // Basic M8 unsigned job.
        dsum = '{16'd10, 16'd20, 16'd30, 16'd0};
        run_job(4'b0000, 3, 1'b1, 0, 8'h00, 0, ra, rs, rw, lat);
        check("basic_res", 64'(ra), 64'd60);
        check("basic_lat", 64'(lat), 64'd2);
        check("basic_mode", 64'(au_ctl_a[3:2]), 64'd0);

        // Signed extension via wNumT, then the same sums unsigned.
        dsum = '{16'hFFFE, 16'h0005, 16'd0, 16'd0};
        run_job(4'b0001, 2, 1'b1, 0, 8'h00, 0, ra, rs, rw, lat);
        check("sx_res_a", 64'(ra), 64'd3);
        check("sx_res_w", 64'(rw), 64'd3);
        run_job(4'b0000, 2, 1'b1, 0, 8'h00, 1, ra, rs, rw, lat);
        check("zx_res_a", 64'(ra), 64'd65539);
        check("zx_res_s", 64'(rs), 64'd65535);
        check("zx_res_w", 64'(rw), 64'd65539);

        // Valid pattern 1,0,0,1 and a result held for 5 cycles.
        dsum = '{16'd100, 16'd23, 16'd0, 16'd0};
        run_job(4'b0000, 2, 1'b1, 0, 8'b0000_1001, 5, ra, rs, rw, lat);
        check("stall_res", 64'(ra), 64'd123);
        check("stall_lat", 64'(lat), 64'd2);

        // Zero-length job.
        run_job(4'b1110, 0, 1'b1, 0, 8'h00, 2, ra, rs, rw, lat);
        check("len0_res", 64'(ra), 64'd0);
        check("len0_lat", 64'(lat), 64'd1);

        // Saturation versus wrap at 17 bits.
        dsum = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0};
        run_job(4'b0010, 3, 1'b1, 0, 8'h00, 0, ra, rs, rw, lat);
        check("sat_res_s", 64'(rs), 64'd65535);
        check("wrap_res_w", 64'(rw), 64'd98301);
        check("sat_res_a", 64'(ra), 64'd98301);

        // Reset in the middle of a 4-beat job after one beat was accumulated.
        cfg_valid = 1'b1; cfg_ctl = 4'b0011; cfg_len = LEN_W'(4);
        @(posedge clk); #1;
        cfg_valid = 1'b0; op_valid = 1'b1; ipix = 16'h1234; wpix = 16'h0101;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags_a", 64'({cfg_ready_a, op_ready_a, res_valid_a, busy_a}), 64'b1000);
        check("mid_rst_flags_w", 64'({cfg_ready_w, op_ready_w, res_valid_w, busy_w}), 64'b1000);
        check("mid_rst_res_a", 64'(res_a), 64'd0);
        check("mid_rst_au_a", 64'({au_ctl_a, au_ipix_a, au_wpix_a}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        dsum = '{16'd7, 16'd0, 16'd0, 16'd0};
        run_job(4'b0000, 1, 1'b1, 0, 8'h00, 0, ra, rs, rw, lat);
        check("post_rst_res", 64'(ra), 64'd7);

        // Randomized jobs.
        for (int j = 0; j < 30; j++) begin
            len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(12, 1));
            run_job(4'($urandom), len, 1'b0, int'($urandom_range(50)), 8'h00,
                    int'($urandom_range(3)), ra, rs, rw, lat);
        end

        // Maximum length at full throughput.
        run_job(4'b0011, 1023, 1'b0, 0, 8'h00, 1, ra, rs, rw, lat);
        check("long_lat", 64'(lat), 64'd2);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
